fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC00000, boot fetch address.
REQ-002 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, exception fetch address.
REQ-003 CLOCK  input  1  single clock; all state on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 STALL  input  1  pipeline hold from hazard unit.
REQ-006 AltPC_IN  input  32  branch/jump target from ID.
REQ-007 AltPCEnable_IN  input  1  ID redirect request, 1-cycle qualifier for AltPC_IN.
REQ-008 JumpRegFor_IN  input  32  forwarded jump-register target.
REQ-009 JumpForward_IN  input  1  forwarded-JR redirect request.
REQ-010 Exception_IN  input  1  exception flush request.
REQ-011 IMReady_IN  input  1  instruction memory accepts/returns current fetch this cycle.
REQ-012 IMRequest_OUT  output  1  fetch request to instruction memory.
REQ-013 InstructionAddress_OUT  output  32  current fetch PC.
REQ-014 InstructionAddressPlus4_OUT  output  32  PC+4 to IF/ID.
REQ-015 FetchValid_OUT  output  1  instruction at current PC completed this cycle; IF/ID may load.
REQ-016 RedirectPending_OUT  output  1  a latched redirect awaits application.

Function
REQ-017 SHALL implement states BOOT, FETCH, WAIT, FLUSH.
REQ-018 BOOT: one cycle after reset release, IMRequest_OUT=0, then unconditionally to FETCH.
REQ-019 FETCH: IMRequest_OUT=1; IMReady_IN=1 and STALL=0 -> advance PC, FetchValid_OUT=1, stay FETCH; IMReady_IN=0 -> WAIT; IMReady_IN=1 and STALL=1 -> stay FETCH, PC unchanged, FetchValid_OUT=0.
REQ-020 WAIT: IMRequest_OUT=1, PC held; IMReady_IN=1 and STALL=0 -> advance PC, FetchValid_OUT=1, to FETCH; otherwise stay WAIT.
REQ-021 FLUSH: exactly one cycle, IMRequest_OUT=0, FetchValid_OUT=0, PC already equals EXC_VECTOR; then to FETCH.
REQ-022 PC advance SHALL load pending target if a redirect is pending, else PC+4 (modulo 2^32, wrap 32'hFFFFFFFC -> 0).
REQ-023 Redirect SHALL apply on the next PC advance after capture, so the instruction at the current PC (delay slot) still completes.
REQ-024 Redirect capture priority: JumpForward_IN over AltPCEnable_IN; both same cycle -> JumpRegFor_IN latched, AltPC_IN dropped.
REQ-025 New redirect while one pending: forwarded-JR overwrites pending target; ID redirect ignored.
REQ-026 Redirect capture SHALL occur regardless of STALL and state; pending cleared on the advance that uses it.
REQ-027 Redirect arriving in the same cycle as an advance SHALL be applied by that advance (combinational bypass), not held.
REQ-028 Exception_IN=1 in any state except BOOT: next cycle PC=EXC_VECTOR, pending redirect cleared, state FLUSH, FetchValid_OUT=0 in the exception cycle; overrides STALL and all redirects.
REQ-029 Exception_IN during BOOT SHALL be ignored.
REQ-030 InstructionAddressPlus4_OUT SHALL always equal InstructionAddress_OUT+4, combinational.
REQ-031 RedirectPending_OUT SHALL be the registered pending flag, not the bypass.

Reset
REQ-032 RESET low SHALL immediately force: PC=RESET_PC, state BOOT, pending=0, pending target=0, IMRequest_OUT=0, FetchValid_OUT=0, RedirectPending_OUT=0.
REQ-033 Reset mid-WAIT or mid-FLUSH SHALL abandon the operation with no residual pending redirect.
REQ-034 Outputs SHALL never be X after reset assertion.

Verification
REQ-035 Reset, IMReady_IN=1, no stall -> BOOT one cycle, then PCs BFC00000, BFC00004, BFC00008 each with FetchValid_OUT=1.
REQ-036 At PC BFC00010, AltPCEnable_IN=1, AltPC_IN=80000000, IMReady_IN=0 for 2 cycles -> RedirectPending_OUT=1, PC held 3 cycles, then PC=80000000, pending=0.
REQ-037 JumpForward_IN and AltPCEnable_IN together (JumpRegFor_IN=80001000, AltPC_IN=80002000) -> next PC 80001000.
REQ-038 STALL=1 for 3 cycles with IMReady_IN=1 -> PC constant, FetchValid_OUT=0; release -> PC+4.
REQ-039 Exception_IN=1 with pending redirect and STALL=1 -> PC=BFC00380, one FLUSH cycle with IMRequest_OUT=0, pending cleared, then fetch BFC00380.
REQ-040 RESET low during WAIT with pending redirect -> PC=BFC00000, RedirectPending_OUT=0 immediately, boot sequence restarts.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the pipeline-side and instruction-memory-side signals of the
// fetch sequencer.
//   master : the surrounding pipeline / memory model (drives hazard, redirect,
//            exception and memory-ready inputs; observes fetch outputs)
//   slave  : the fetch sequencer itself
// Signals:
//   STALL                        hold request from the hazard unit
//   AltPC_IN / AltPCEnable_IN    branch/jump target from ID and its qualifier
//   JumpRegFor_IN / JumpForward_IN forwarded jump-register target and request
//   Exception_IN                 exception flush request
//   IMReady_IN                   instruction memory completes the fetch
//   IMRequest_OUT                fetch request to instruction memory
//   InstructionAddress_OUT       current fetch PC
//   InstructionAddressPlus4_OUT  current fetch PC + 4
//   FetchValid_OUT               instruction at current PC completed
//   RedirectPending_OUT          a latched redirect awaits application
// ---------------------------------------------------------------------------
interface fetch_sequencer_if;
  logic        STALL;
  logic [31:0] AltPC_IN;
  logic        AltPCEnable_IN;
  logic [31:0] JumpRegFor_IN;
  logic        JumpForward_IN;
  logic        Exception_IN;
  logic        IMReady_IN;
  logic        IMRequest_OUT;
  logic [31:0] InstructionAddress_OUT;
  logic [31:0] InstructionAddressPlus4_OUT;
  logic        FetchValid_OUT;
  logic        RedirectPending_OUT;

  modport master (
    output STALL, AltPC_IN, AltPCEnable_IN, JumpRegFor_IN, JumpForward_IN,
           Exception_IN, IMReady_IN,
    input  IMRequest_OUT, InstructionAddress_OUT, InstructionAddressPlus4_OUT,
           FetchValid_OUT, RedirectPending_OUT
  );

  modport slave (
    input  STALL, AltPC_IN, AltPCEnable_IN, JumpRegFor_IN, JumpForward_IN,
           Exception_IN, IMReady_IN,
    output IMRequest_OUT, InstructionAddress_OUT, InstructionAddressPlus4_OUT,
           FetchValid_OUT, RedirectPending_OUT
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch PC sequencer. Walks the PC through boot, normal fetch,
// memory wait and exception flush, holding redirects (branch/jump targets)
// until the instruction in the delay slot has completed.
// Ports:
//   CLOCK  rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    fetch_sequencer_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input logic              CLOCK,
  input logic              RESET,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] target_q, target_d;

  logic        bypass_pending;
  logic [31:0] bypass_target;
  logic        advance;
  logic        im_request;

  // Merge this cycle's redirect request into the latched one. A forwarded JR
  // always wins (and overwrites a pending target); an ID redirect is only
  // taken when nothing is already pending.
  always_comb begin
    bypass_pending = pending_q;
    bypass_target  = target_q;
    if (bus.JumpForward_IN) begin
      bypass_pending = 1'b1;
      bypass_target  = bus.JumpRegFor_IN;
    end else if (bus.AltPCEnable_IN && !pending_q) begin
      bypass_pending = 1'b1;
      bypass_target  = bus.AltPC_IN;
    end
  end

  // Next-state, PC and output logic. FETCH and WAIT differ only in where an
  // unready memory leaves us; both hold the PC until the fetch completes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = bypass_pending;
    target_d   = bypass_target;
    advance    = 1'b0;
    im_request = 1'b0;

    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        im_request = 1'b1;
        if (!bus.IMReady_IN)  state_d = WAIT;
        else if (!bus.STALL)  advance = 1'b1;
      end
      WAIT: begin
        im_request = 1'b1;
        if (bus.IMReady_IN && !bus.STALL) begin
          advance = 1'b1;
          state_d = FETCH;
        end
      end
      FLUSH:   state_d = FETCH;
      default: state_d = BOOT;
    endcase

    if (advance) begin
      pc_d      = bypass_pending ? bypass_target : pc_q + 32'd4;
      pending_d = 1'b0;
    end

    // An exception beats stalls and redirects; it is ignored while booting.
    if (bus.Exception_IN && (state_q != BOOT)) begin
      advance   = 1'b0;
      state_d   = FLUSH;
      pc_d      = EXC_VECTOR;
      pending_d = 1'b0;
      target_d  = 32'd0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      target_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  assign bus.IMRequest_OUT               = im_request;
  assign bus.InstructionAddress_OUT      = pc_q;
  assign bus.InstructionAddressPlus4_OUT = pc_q + 32'd4;
  assign bus.FetchValid_OUT              = advance;
  assign bus.RedirectPending_OUT         = pending_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC   = 32'hBFC00000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  logic CLOCK;
  logic RESET;

  fetch_sequencer_if bus_if ();

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model: phase 0 = booting, 1 = running (fetching or waiting on
  // memory, which look identical from outside), 2 = flushing.
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  task automatic modelReset();
    m_phase = 0;
    m_pc    = RESET_PC;
    m_pend  = 1'b0;
    m_tgt   = 32'd0;
  endtask

  // Called just after a falling edge: asserts reset, checks the immediate
  // effect, holds it across one rising edge and releases at the next fall.
  task automatic resetDut();
    RESET = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_pc",      bus_if.InstructionAddress_OUT, RESET_PC);
    checkOutput("rst_pc4",     bus_if.InstructionAddressPlus4_OUT, RESET_PC + 32'd4);
    checkOutput("rst_req",     {31'd0, bus_if.IMRequest_OUT}, 32'd0);
    checkOutput("rst_valid",   {31'd0, bus_if.FetchValid_OUT}, 32'd0);
    checkOutput("rst_pending", {31'd0, bus_if.RedirectPending_OUT}, 32'd0);
    @(negedge CLOCK);
    RESET = 1'b1;
  endtask

  // Drives one cycle of inputs just after a falling edge, checks every output
  // against the model, steps the model, and returns after the next fall.
  task automatic applyStimulus(input logic rdy, input logic stl,
                               input logic alt, input logic [31:0] altPc,
                               input logic jf, input logic [31:0] jrPc,
                               input logic exc);
    logic exp_req;
    logic exp_valid;
    bus_if.IMReady_IN     = rdy;
    bus_if.STALL          = stl;
    bus_if.AltPCEnable_IN = alt;
    bus_if.AltPC_IN       = altPc;
    bus_if.JumpForward_IN = jf;
    bus_if.JumpRegFor_IN  = jrPc;
    bus_if.Exception_IN   = exc;
    #1;
    exp_req   = (m_phase == 1);
    exp_valid = (m_phase == 1) && rdy && !stl && !exc;
    checkOutput("pc",      bus_if.InstructionAddress_OUT, m_pc);
    checkOutput("pc4",     bus_if.InstructionAddressPlus4_OUT, m_pc + 32'd4);
    checkOutput("req",     {31'd0, bus_if.IMRequest_OUT}, {31'd0, exp_req});
    checkOutput("valid",   {31'd0, bus_if.FetchValid_OUT}, {31'd0, exp_valid});
    checkOutput("pending", {31'd0, bus_if.RedirectPending_OUT}, {31'd0, m_pend});

    if (m_phase != 0 && exc) begin
      m_pc    = EXC_VECTOR;
      m_pend  = 1'b0;
      m_phase = 2;
    end else begin
      if (jf) begin
        m_pend = 1'b1;
        m_tgt  = jrPc;
      end else if (alt && !m_pend) begin
        m_pend = 1'b1;
        m_tgt  = altPc;
      end
      if (exp_valid) begin
        m_pc   = m_pend ? m_tgt : m_pc + 32'd4;
        m_pend = 1'b0;
      end
      m_phase = 1;
    end
    @(negedge CLOCK);
  endtask

  task automatic idleCycle(input logic rdy, input logic stl);
    applyStimulus(rdy, stl, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    RESET                 = 1'b0;
    bus_if.IMReady_IN     = 1'b0;
    bus_if.STALL          = 1'b0;
    bus_if.AltPCEnable_IN = 1'b0;
    bus_if.AltPC_IN       = 32'd0;
    bus_if.JumpForward_IN = 1'b0;
    bus_if.JumpRegFor_IN  = 32'd0;
    bus_if.Exception_IN   = 1'b0;
    modelReset();
    @(negedge CLOCK);
    resetDut();

    // Boot then straight-line fetch to BFC00010.
    idleCycle(1'b1, 1'b0);
    repeat (4) idleCycle(1'b1, 1'b0);
    checkOutput("boot_seq_pc", bus_if.InstructionAddress_OUT, 32'hBFC00010);

    // ID redirect captured while memory is slow; applied after the delay slot.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 32'd0, 1'b0);
    idleCycle(1'b0, 1'b0);
    idleCycle(1'b1, 1'b0);
    checkOutput("redirect_pc", bus_if.InstructionAddress_OUT, 32'h80000000);

    // Forwarded JR beats a simultaneous ID redirect (bypassed into this advance).
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80002000, 1'b1, 32'h80001000, 1'b0);
    checkOutput("priority_pc", bus_if.InstructionAddress_OUT, 32'h80001000);

    // Stall for three cycles, then release.
    repeat (3) idleCycle(1'b1, 1'b1);
    idleCycle(1'b1, 1'b0);
    checkOutput("stall_pc", bus_if.InstructionAddress_OUT, 32'h80001004);

    // Exception with a pending redirect and a stall.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h12340000, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    checkOutput("exc_pc", bus_if.InstructionAddress_OUT, EXC_VECTOR);
    idleCycle(1'b1, 1'b0);
    idleCycle(1'b1, 1'b0);
    checkOutput("exc_next_pc", bus_if.InstructionAddress_OUT, EXC_VECTOR + 32'd4);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFFC, 1'b0);
    idleCycle(1'b1, 1'b0);
    checkOutput("wrap_pc", bus_if.InstructionAddress_OUT, 32'h00000000);

    // Reset during WAIT with a redirect pending; exception in BOOT is ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h55555550, 1'b0, 32'd0, 1'b0);
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    repeat (3) idleCycle(1'b1, 1'b0);
    checkOutput("reboot_pc", bus_if.InstructionAddress_OUT, 32'hBFC0000C);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetDut();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 6) == 0,
                      $urandom() & 32'hFFFFFFFC,
                      $urandom_range(0, 9) == 0,
                      ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC),
                      $urandom_range(0, 39) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
